// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage port bundle: SRAM-like instruction port, redirect/flush inputs and F/D output handshake.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface inst_fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        post_allowin;
    logic        goon_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [2:0]  sig_exc;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  redirect_valid, redirect_pc, flush_valid, flush_pc,
        input  post_allowin,
        output goon_valid, pc, instruction, sig_exc
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output redirect_valid, redirect_pc, flush_valid, flush_pc,
        output post_allowin,
        input  goon_valid, pc, instruction, sig_exc
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// Fetch stage: single-outstanding instruction requests into a one-entry output buffer (3 cycles/instr with zero-wait memory).
// Buffer holds stable until post_allowin; redirects take effect after the delay slot, flushes immediately.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_stage_if.master fs
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  exc;
    } buf_t;

    state_t      state;
    logic [31:0] fetch_pc;
    buf_t        buf_q;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic        cancel;

    logic        aligned;
    logic [31:0] next_pc;

    assign aligned        = (fetch_pc[1:0] == 2'b00);
    assign fs.inst_req    = (state == REQ) && aligned;
    assign fs.inst_addr   = fetch_pc;
    assign fs.goon_valid  = (state == FULL);
    assign fs.pc          = buf_q.pc;
    assign fs.instruction = buf_q.inst;
    assign fs.sig_exc     = buf_q.exc;

    // Address after the buffer load; a redirect arriving on the load cycle targets the instruction after this slot.
    always_comb begin
        next_pc = fetch_pc + 32'd4;
        if (fs.redirect_valid) begin
            next_pc = fs.redirect_pc;
        end else if (pend_valid) begin
            next_pc = pend_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            buf_q      <= '0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            cancel     <= 1'b0;
        end else if (fs.flush_valid) begin
            fetch_pc   <= fs.flush_pc;
            pend_valid <= 1'b0;
            case (state)
                REQ: begin
                    if (fs.inst_req && fs.inst_addr_ok) begin
                        state  <= WAIT;
                        cancel <= 1'b1;
                    end else begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (fs.inst_data_ok) begin
                        state  <= REQ;
                        cancel <= 1'b0;
                    end else begin
                        cancel <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            // Outside FULL the delay slot is still in flight, so the target waits in pend_pc.
            if (fs.redirect_valid && state != FULL) begin
                pend_valid <= 1'b1;
                pend_pc    <= fs.redirect_pc;
            end
            if (fs.redirect_valid && state == FULL) begin
                fetch_pc <= fs.redirect_pc;
            end
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (!aligned) begin
                        buf_q      <= '{pc: fetch_pc, inst: 32'd0, exc: 3'b001};
                        fetch_pc   <= next_pc;
                        pend_valid <= 1'b0;
                        state      <= FULL;
                    end else if (fs.inst_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fs.inst_data_ok) begin
                        if (cancel) begin
                            cancel <= 1'b0;
                            state  <= REQ;
                        end else begin
                            buf_q      <= '{pc: fetch_pc, inst: fs.inst_rdata, exc: 3'b000};
                            fetch_pc   <= next_pc;
                            pend_valid <= 1'b0;
                            state      <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (fs.post_allowin) begin
                        state <= REQ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage: a memory model answers requests, a negedge monitor checks
// issued addresses and consumed outputs against queues filled by the directed scenarios.
module tb_inst_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  exc;
    } out_t;

    logic clk;
    logic reset;
    logic addr_ok_en;
    int   lat;
    logic force_en;
    int   mem_cnt;
    logic [31:0] mem_data;
    int   cyc_n;
    int   total;
    int   bad;
    int   c0;
    int   c1;

    logic [31:0] exp_req[$];
    out_t        exp_out[$];

    inst_fetch_stage_if ifc ();

    inst_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (ifc.master)
    );

    assign ifc.inst_addr_ok = ifc.inst_req & addr_ok_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc_n = 0;
        forever @(posedge clk) cyc_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC00004) return 32'h24080001;
        return a ^ 32'h5555AAAA;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        exp_req.push_back(a);
        exp_out.push_back('{pc: a, inst: mem_word(a), exc: 3'b000});
    endtask

    task automatic wait_out(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.goon_valid && ifc.pc == a) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_out timeout actual=none expected=%h", a);
        end
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.inst_req && ifc.inst_addr_ok && ifc.inst_addr == a) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_req timeout actual=none expected=%h", a);
        end
    endtask

    // Instruction memory: the word is latched at accept and returned lat cycles later.
    initial begin
        mem_cnt = 0;
        mem_data = '0;
        ifc.inst_data_ok = 1'b0;
        ifc.inst_rdata = '0;
        forever begin
            @(negedge clk);
            ifc.inst_data_ok = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    ifc.inst_data_ok = 1'b1;
                    ifc.inst_rdata = mem_data;
                end
            end
            if (ifc.inst_req && ifc.inst_addr_ok) begin
                mem_cnt = lat;
                mem_data = force_en ? 32'hDEADBEEF : mem_word(ifc.inst_addr);
            end
        end
    end

    initial begin
        out_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (ifc.inst_req && ifc.inst_addr_ok) begin
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req actual=%h expected=none", ifc.inst_addr);
                end else begin
                    ea = exp_req.pop_front();
                    chk("req_addr", ifc.inst_addr, ea);
                end
            end
            if (ifc.goon_valid && ifc.post_allowin) begin
                if (exp_out.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%h/%h expected=none", ifc.pc, ifc.instruction);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_pc", ifc.pc, e.pc);
                    chk("out_inst", ifc.instruction, e.inst);
                    chk("out_exc", 32'(ifc.sig_exc), 32'(e.exc));
                end
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        addr_ok_en = 1'b1;
        lat = 1;
        force_en = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = '0;
        ifc.flush_valid = 1'b0;
        ifc.flush_pc = '0;
        ifc.post_allowin = 1'b1;
        step(3);
        chk("rst_inst_req", 32'(ifc.inst_req), 32'd0);
        chk("rst_inst_addr", ifc.inst_addr, RESET_PC);
        chk("rst_goon_valid", 32'(ifc.goon_valid), 32'd0);
        chk("rst_pc", ifc.pc, 32'd0);
        chk("rst_instruction", ifc.instruction, 32'd0);
        chk("rst_sig_exc", 32'(ifc.sig_exc), 32'd0);

        // Zero-wait streaming, then a 5-cycle stall on the second instruction.
        fetch(32'hBFC00000);
        fetch(32'hBFC00004);
        fetch(32'hBFC00008);
        reset = 1'b0;
        step(1);
        chk("first_req", 32'(ifc.inst_req), 32'd1);
        wait_out(32'hBFC00000);
        c0 = cyc_n;
        step(1);
        wait_out(32'hBFC00004);
        c1 = cyc_n;
        chk("issue_interval", 32'(c1 - c0), 32'd3);
        ifc.post_allowin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_goon_valid", 32'(ifc.goon_valid), 32'd1);
            chk("stall_pc", ifc.pc, 32'hBFC00004);
            chk("stall_instruction", ifc.instruction, 32'h24080001);
            chk("stall_inst_req", 32'(ifc.inst_req), 32'd0);
        end
        lat = 2;
        ifc.post_allowin = 1'b1;

        // Redirect while the delay slot is in WAIT.
        fetch(32'hBFC00100);
        wait_req(32'hBFC00008);
        step(1);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'hBFC00100;
        step(1);
        ifc.redirect_valid = 1'b0;
        lat = 1;

        // Redirect while the delay slot sits in the buffer.
        fetch(32'hBFC00104);
        fetch(32'hBFC00200);
        wait_out(32'hBFC00104);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'hBFC00200;
        step(1);
        ifc.redirect_valid = 1'b0;

        // Flush during WAIT: the late 0xDEADBEEF response must be dropped.
        exp_req.push_back(32'hBFC00204);
        fetch(32'hBFC00380);
        wait_out(32'hBFC00200);
        lat = 3;
        force_en = 1'b1;
        wait_req(32'hBFC00204);
        step(1);
        ifc.flush_valid = 1'b1;
        ifc.flush_pc = 32'hBFC00380;
        step(1);
        ifc.flush_valid = 1'b0;
        force_en = 1'b0;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            chk("flush_goon_valid", 32'(ifc.goon_valid), 32'd0);
            step(1);
        end

        // Redirect to a misaligned target: address error without a request.
        fetch(32'hBFC00384);
        exp_out.push_back('{pc: 32'hBFC00102, inst: 32'd0, exc: 3'b001});
        fetch(32'hBFC00400);
        wait_req(32'hBFC00384);
        step(1);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'hBFC00102;
        step(1);
        ifc.redirect_valid = 1'b0;
        wait_out(32'hBFC00102);
        chk("adel_sig_exc", 32'(ifc.sig_exc), 32'd1);
        chk("adel_instruction", ifc.instruction, 32'd0);
        step(1);
        ifc.flush_valid = 1'b1;
        ifc.flush_pc = 32'hBFC00400;
        step(1);
        ifc.flush_valid = 1'b0;

        // Reset during WAIT; the stale response lands while the stage is back in REQ.
        exp_req.push_back(32'hBFC00404);
        wait_out(32'hBFC00400);
        lat = 3;
        wait_req(32'hBFC00404);
        step(1);
        reset = 1'b1;
        addr_ok_en = 1'b0;
        lat = 1;
        #1;
        chk("midrst_inst_req", 32'(ifc.inst_req), 32'd0);
        chk("midrst_goon_valid", 32'(ifc.goon_valid), 32'd0);
        chk("midrst_pc", ifc.pc, 32'd0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("postrst_inst_req", 32'(ifc.inst_req), 32'd1);
        chk("postrst_inst_addr", ifc.inst_addr, RESET_PC);
        fetch(RESET_PC);
        addr_ok_en = 1'b1;
        step(1);
        addr_ok_en = 1'b0;
        wait_out(RESET_PC);
        step(3);

        chk("req_queue_left", 32'(exp_req.size()), 32'd0);
        chk("out_queue_left", 32'(exp_out.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Fetch stage of the five-stage f-d-e-m-w pipeline. Generates the fetch PC, issues single-outstanding requests on the SRAM-like instruction port, holds the returned word in a one-entry output buffer, and presents it to the F/D pipeline register through the valid/allowin handshake. Applies branch redirects after the delay slot and exception flushes immediately, discarding any in-flight response.

## Interface
- RESET_PC, 32'hBFC00000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inst_req  out  1  instruction request valid
- inst_addr  out  32  request address (= fetch_pc)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response valid this cycle
- inst_rdata  in  32  response word
- redirect_valid  in  1  branch/jump taken, one-cycle pulse from decode
- redirect_pc  in  32  branch target
- flush_valid  in  1  exception/eret flush, one-cycle pulse
- flush_pc  in  32  handler/return address
- post_allowin  in  1  F/D register accepts this cycle
- goon_valid  out  1  buffer holds a valid instruction
- pc  out  32  PC of buffered instruction
- instruction  out  32  buffered instruction word
- sig_exc  out  3  3'b001 = fetch address error, else 3'b000

## Operation
- Registers: state {IDLE, REQ, WAIT, FULL}, fetch_pc, buf_pc, buf_inst, buf_exc, pend_valid, pend_pc, cancel.
- inst_req = (state==REQ) && fetch_pc[1:0]==0; inst_addr = fetch_pc.
- goon_valid = (state==FULL); pc/instruction/sig_exc driven from buf_* registers.
- IDLE -> REQ unconditionally (one cycle after reset release).
- REQ, fetch_pc[1:0]!=0: no request; load buf_pc=fetch_pc, buf_inst=0, buf_exc=3'b001; -> FULL.
- REQ, aligned: hold inst_req until inst_addr_ok; then -> WAIT.
- WAIT, inst_data_ok: if cancel, drop word, clear cancel, -> REQ. Else buf_pc=fetch_pc, buf_inst=inst_rdata, buf_exc=0, -> FULL.
- Buffer load (either kind): fetch_pc <= pend_valid ? pend_pc : fetch_pc+4 (32-bit wrap); pend_valid cleared.
- FULL, post_allowin: buffer consumed; -> REQ. Otherwise hold all buf_* stable.
- redirect_valid: the instruction in flight or in buffer is the delay slot. If state==FULL, fetch_pc <= redirect_pc immediately. Otherwise pend_valid<=1, pend_pc<=redirect_pc. Second redirect before load overwrites pend_pc.
- flush_valid: fetch_pc<=flush_pc; pend_valid<=0; buffer dropped. From FULL or REQ without accept -> REQ. From WAIT without inst_data_ok, or REQ with inst_addr_ok same cycle -> WAIT with cancel=1. From WAIT with inst_data_ok same cycle -> REQ, word dropped.
- flush_valid has priority over redirect_valid and over any buffer load in the same cycle.

## Timing
- Reset values: state=IDLE, fetch_pc=RESET_PC, inst_req=0, goon_valid=0, pc=0, instruction=0, sig_exc=0, pend_valid=0, cancel=0.
- Reset asserted mid-transaction: state returns to IDLE asynchronously; responses arriving in IDLE/REQ are ignored.
- Best case with zero-wait memory: request cycle N, inst_data_ok N+1, goon_valid N+2, next inst_req N+3 when post_allowin=1 at N+2 (one instruction per 3 cycles).
- inst_req and inst_addr stay stable while waiting for inst_addr_ok unless flush_valid arrives (address changes next cycle).
- At most one request outstanding; no new request while in WAIT.
- goon_valid never drops without post_allowin or flush_valid.

## Test plan
- Reset release, memory addr_ok/data_ok zero-wait, post_allowin=1 -> requests at 0xBFC00000, 0xBFC00004, 0xBFC00008; outputs pc match with goon_valid every third cycle.
- post_allowin=0 for 5 cycles with buffer FULL holding 0x24080001 @0xBFC00004 -> goon_valid, pc, instruction constant; no inst_req; resumes at 0xBFC00008 after allowin.
- redirect_valid pc=0xBFC00100 while WAIT for delay slot 0xBFC00008 -> delay slot delivered, next request 0xBFC00100; repeat with redirect during FULL -> same result.
- flush_valid pc=0xBFC00380 during WAIT, data_ok two cycles later with 0xDEADBEEF -> word never appears, goon_valid stays 0, next request 0xBFC00380.
- redirect_pc=0xBFC00102 -> after delay slot, no request issued; goon_valid with pc=0xBFC00102, instruction=0, sig_exc=3'b001.
- Assert reset during WAIT, send data_ok afterwards -> ignored; first request after release at RESET_PC.
